// File: rtl/fp_multiplier_seq.sv
// Iterative IEEE-754 single-precision multiplier: unpack, shift-add significand product,
// normalise (including subnormal results) and round-to-nearest-even. Fixed latency 24/RADIX_BITS+3.
module fp_multiplier_seq #(
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] p
);

    localparam int unsigned STEPS = 24 / RADIX_BITS;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned DW    = 24 + RADIX_BITS;
    localparam int unsigned PW    = 49 + RADIX_BITS;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND} state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d, p_q, p_d;
    logic               s_q, s_d, zero_q, zero_d, sticky_q, sticky_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [23:0]        ma_q, ma_d;
    logic [47:0]        prod_q, prod_d;
    logic signed [9:0]  e_q, e_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [46:0]        m_q, m_d;

    logic [33:0]        ua, ub;
    logic [DW-1:0]      pp;
    logic [PW-1:0]      sum;
    logic [47:0]        nm, mask;
    logic signed [9:0]  ne, ef;
    logic               nst, up;
    logic [9:0]         sh;
    logic [23:0]        sig;
    logic [24:0]        rs;

    // Returns {effective exponent, significand normalised so bit 23 is set unless zero}.
    function automatic logic [33:0] unpack_op(input logic [30:0] x);
        logic [23:0] m;
        logic [4:0]  lz;
        logic [9:0]  e;
        m  = {(x[30:23] != 8'd0), x[22:0]};
        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (m[i]) lz = 5'(23 - i);
        end
        e = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
        return {e - {5'd0, lz}, m << lz};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_UNPACK;
            S_UNPACK: state_d = S_MULT;
            S_MULT:   if (cnt_q == CW'(STEPS - 1)) state_d = S_NORM;
            S_NORM:   state_d = S_ROUND;
            S_ROUND:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d = a_q;  b_d = b_q;  p_d = p_q;
        s_d = s_q;  zero_d = zero_q;  sticky_d = sticky_q;
        ma_d = ma_q;  prod_d = prod_q;  e_d = e_q;  cnt_d = cnt_q;  m_d = m_q;
        busy_d = 1'b0;
        done_d = 1'b0;

        ua  = unpack_op(a_q[30:0]);
        ub  = unpack_op(b_q[30:0]);
        pp  = DW'(ma_q) * DW'(prod_q[RADIX_BITS-1:0]);
        sum = PW'(prod_q) + (PW'(pp) << 24);

        // Bring the product to 1.x (bit 46), then denormalise if the exponent underflowed.
        nm = prod_q;  ne = e_q;  nst = 1'b0;  sh = 10'd0;  mask = 48'd0;
        if (nm[47]) begin
            nst = nm[0];
            nm  = nm >> 1;
            ne  = ne + 10'sd1;
        end
        if (ne <= 10'sd0) begin
            sh = 10'(10'sd1 - ne);
            if (sh > 10'd26) sh = 10'd26;
            mask = ~(48'hFFFF_FFFF_FFFF << sh);
            nst  = nst | (|(nm & mask));
            nm   = nm >> sh;
            ne   = 10'sd0;
        end

        sig = m_q[46:23];
        up  = m_q[22] & (sticky_q | (|m_q[21:0]) | sig[0]);
        rs  = {1'b0, sig} + 25'(up);
        if (e_q == 10'sd0) ef = rs[23] ? 10'sd1 : 10'sd0;
        else               ef = e_q + $signed({9'd0, rs[24]});

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d = a;
                    b_d = b;
                end
            end
            S_UNPACK: begin
                s_d    = a_q[31] ^ b_q[31];
                zero_d = (ua[23:0] == 24'd0) || (ub[23:0] == 24'd0);
                ma_d   = ua[23:0];
                prod_d = {24'd0, ub[23:0]};
                e_d    = $signed(ua[33:24]) + $signed(ub[33:24]) - 10'sd127;
                cnt_d  = '0;
                busy_d = 1'b1;
            end
            S_MULT: begin
                prod_d = 48'(sum >> RADIX_BITS);
                cnt_d  = cnt_q + CW'(1);
                busy_d = 1'b1;
            end
            S_NORM: begin
                m_d      = nm[46:0];
                e_d      = ne;
                sticky_d = nst;
                busy_d   = 1'b1;
            end
            S_ROUND: begin
                done_d = 1'b1;
                if (zero_q)             p_d = {s_q, 31'd0};
                else if (ef >= 10'sd255) p_d = {s_q, 8'hFF, 23'd0};
                else                    p_d = {s_q, ef[7:0], rs[22:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;  b_q <= '0;  p_q <= '0;
            s_q <= 1'b0;  zero_q <= 1'b0;  sticky_q <= 1'b0;
            busy_q <= 1'b0;  done_q <= 1'b0;
            ma_q <= '0;  prod_q <= '0;  e_q <= '0;  cnt_q <= '0;  m_q <= '0;
        end else begin
            a_q <= a_d;  b_q <= b_d;  p_q <= p_d;
            s_q <= s_d;  zero_q <= zero_d;  sticky_q <= sticky_d;
            busy_q <= busy_d;  done_q <= done_d;
            ma_q <= ma_d;  prod_q <= prod_d;  e_q <= e_d;  cnt_q <= cnt_d;  m_q <= m_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule
